// File: rtl/out_display.sv
// Four-digit multiplexed seven-segment driver for an 8-bit CPU output register.
// Binary is converted to BCD by a serial double-dabble FSM; an optional sign digit shows negatives.
module out_display #(
  parameter int SCAN_DIV    = 1000,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_out,
  input  logic       i_load,
  output logic [6:0] o_seg,
  output logic [3:0] o_an,
  output logic       o_busy
);

  localparam int         CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  bin;
  logic [11:0] bcd, bcd_adj;
  logic        conv_sign;
  logic [2:0]  shift_cnt;
  logic        pend;
  logic [7:0]  pend_val;
  logic [3:0]  disp_h, disp_t, disp_o;
  logic        disp_sign;
  logic [CW-1:0] scan_cnt;
  logic [1:0]  digit;
  logic        start;
  logic [7:0]  start_val;
  logic [19:0] dd_next;
  logic [6:0]  seg_nxt;

  // Returns {sign, magnitude}; in signed mode 8'h80 becomes magnitude 128.
  function automatic logic [8:0] split(input logic [7:0] v);
    if (SIGNED_MODE && v[7]) return {1'b1, ~v + 8'd1};
    return {1'b0, v};
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: each combinational output is assigned a default first so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_load) state_nxt = CONVERT;
      CONVERT: if (shift_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = (i_load || pend) ? CONVERT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  // A fresh load at DONE takes priority over the pending value.
  always_comb begin
    start     = (state == IDLE && i_load) || (state == DONE && (i_load || pend));
    start_val = (state == DONE && !i_load) ? pend_val : i_out;
    bcd_adj   = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    dd_next   = {bcd_adj, bin} << 1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bin       <= '0;
      bcd       <= '0;
      conv_sign <= 1'b0;
      shift_cnt <= '0;
      pend      <= 1'b0;
      pend_val  <= '0;
      disp_h    <= '0;
      disp_t    <= '0;
      disp_o    <= '0;
      disp_sign <= 1'b0;
    end else begin
      if (start) begin
        {conv_sign, bin} <= split(start_val);
        bcd              <= '0;
        shift_cnt        <= '0;
      end else if (state == CONVERT) begin
        {bcd, bin} <= dd_next;
        shift_cnt  <= shift_cnt + 3'd1;
      end

      if (state == CONVERT && i_load) begin
        pend     <= 1'b1;
        pend_val <= i_out;
      end else if (state == DONE) begin
        pend <= 1'b0;
      end

      if (state == DONE) begin
        disp_h    <= bcd[11:8];
        disp_t    <= bcd[7:4];
        disp_o    <= bcd[3:0];
        disp_sign <= conv_sign;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Leading-zero blanking: tens hide only when hundreds are also zero.
  always_comb begin
    seg_nxt = BLANK;
    case (digit)
      2'd0: seg_nxt = seg7(disp_o);
      2'd1: seg_nxt = (disp_h == 4'd0 && disp_t == 4'd0) ? BLANK : seg7(disp_t);
      2'd2: seg_nxt = (disp_h == 4'd0) ? BLANK : seg7(disp_h);
      2'd3: seg_nxt = disp_sign ? MINUS : BLANK;
      default: seg_nxt = BLANK;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_seg <= BLANK;
      o_an  <= 4'b1111;
    end else begin
      o_seg <= seg_nxt;
      o_an  <= ~(4'b0001 << digit);
    end
  end

endmodule

// File: tb/tb_out_display.sv
// Bench for out_display: an unsigned and a signed instance share stimulus and are
// compared every cycle against a value-level model of conversion timing and display.
module tb_out_display;

  localparam int SCAN_DIV = 4;
  localparam logic [6:0] CODES [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] out_val = '0;
  logic       load = 1'b0;
  logic [6:0] seg_u, seg_s;
  logic [3:0] an_u, an_s;
  logic       busy_u, busy_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since reset release, active job, pending slot, shown values.
  int         edges;
  bit         job_active;
  int         job_age;
  logic [7:0] job_val;
  bit         pend_ok;
  logic [7:0] pend_v;
  int         disp_u, disp_s;
  logic       exp_busy;
  logic [3:0] exp_an;
  logic [6:0] exp_seg_u, exp_seg_s;

  out_display #(.SCAN_DIV(SCAN_DIV), .SIGNED_MODE(1'b0)) u_uns (
    .i_clk(clk), .i_rst(rst_n), .i_out(out_val), .i_load(load),
    .o_seg(seg_u), .o_an(an_u), .o_busy(busy_u)
  );

  out_display #(.SCAN_DIV(SCAN_DIV), .SIGNED_MODE(1'b1)) u_sgn (
    .i_clk(clk), .i_rst(rst_n), .i_out(out_val), .i_load(load),
    .o_seg(seg_s), .o_an(an_s), .o_busy(busy_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v, input int idx);
    int mag, h, t, o;
    mag = (v < 0) ? -v : v;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    case (idx)
      0:       return CODES[o];
      1:       return (h == 0 && t == 0) ? BLANK : CODES[t];
      2:       return (h == 0) ? BLANK : CODES[h];
      default: return (v < 0) ? MINUS : BLANK;
    endcase
  endfunction

  task automatic start_job(input logic [7:0] d);
    job_active = 1'b1;
    job_age    = 0;
    job_val    = d;
  endtask

  // One rising edge of the model, given the inputs sampled at that edge.
  task automatic model_edge(input bit ld, input logic [7:0] d);
    int idx;
    idx       = (edges / SCAN_DIV) % 4;
    exp_an    = ~(4'b0001 << idx);
    exp_seg_u = seg_of(disp_u, idx);
    exp_seg_s = seg_of(disp_s, idx);
    edges++;
    if (!job_active) begin
      if (ld) start_job(d);
    end else begin
      job_age++;
      if (job_age < 9) begin
        if (ld) begin
          pend_ok = 1'b1;
          pend_v  = d;
        end
      end else begin
        disp_u = int'(job_val);
        disp_s = (job_val >= 8'd128) ? int'(job_val) - 256 : int'(job_val);
        if (ld) begin
          start_job(d);
          pend_ok = 1'b0;
        end else if (pend_ok) begin
          start_job(pend_v);
          pend_ok = 1'b0;
        end else begin
          job_active = 1'b0;
        end
      end
    end
    exp_busy = job_active;
  endtask

  task automatic step(input bit ld, input logic [7:0] d);
    load    = ld;
    out_val = d;
    @(posedge clk);
    model_edge(ld, d);
    @(negedge clk);
    load = 1'b0;
    check("busy_u", busy_u, exp_busy);
    check("busy_s", busy_s, exp_busy);
    check("an_u", an_u, exp_an);
    check("an_s", an_s, exp_an);
    check("seg_u", seg_u, exp_seg_u);
    check("seg_s", seg_s, exp_seg_s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy_u", busy_u, 1'b0);
    check("rst_busy_s", busy_s, 1'b0);
    check("rst_an_u", an_u, 4'b1111);
    check("rst_an_s", an_s, 4'b1111);
    check("rst_seg_u", seg_u, BLANK);
    check("rst_seg_s", seg_s, BLANK);
  endtask

  // Called just after a falling edge; reset spans one rising edge.
  task automatic do_reset();
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    edges      = 0;
    job_active = 1'b0;
    job_age    = 0;
    pend_ok    = 1'b0;
    disp_u     = 0;
    disp_s     = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    step(1'b0, 8'd0);
    check("first_an", an_u, 4'b1110);
    check("first_seg", seg_u, 7'b1000000);
    idle(3);

    step(1'b1, 8'd255);
    idle(30);
    step(1'b1, 8'd7);
    idle(30);
    step(1'b1, 8'hF6);
    idle(30);
    step(1'b1, 8'h80);
    idle(30);
    step(1'b1, 8'd105);
    idle(30);

    // Back-to-back: 34 is overwritten by 56 in the pending slot.
    step(1'b1, 8'd12);
    idle(2);
    step(1'b1, 8'd34);
    idle(2);
    step(1'b1, 8'd56);
    idle(40);

    // Load arriving exactly on the commit edge.
    step(1'b1, 8'd99);
    idle(8);
    step(1'b1, 8'd240);
    idle(30);

    // Reset during a conversion discards it.
    step(1'b1, 8'd200);
    idle(3);
    do_reset();
    idle(30);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 6) == 0, 8'($urandom));
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/out_display.md
OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles per digit slot (legal >= 2).
REQ-002 SHALL have parameter SIGNED_MODE, default 0; 0 = unsigned, 1 = two's complement.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port i_out, input, 8, CPU output-register value.
REQ-006 SHALL have port i_load, input, 1, single-cycle strobe when the CPU writes its output register.
REQ-007 SHALL have port o_seg, output, 7, {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 SHALL have port o_an, output, 4, active-low one-hot digit enable, registered.
REQ-009 SHALL have port o_busy, output, 1, high while a conversion is in progress.

Function
REQ-010 FSM states SHALL be IDLE, CONVERT, DONE; o_busy = (state != IDLE).
REQ-011 i_load high in IDLE at edge N SHALL capture i_out, enter CONVERT, clear the 3-bit shift counter.
REQ-012 Conversion SHALL be double-dabble, one shift per cycle at edges N+1..N+8; after edge N+8 state = DONE.
- Add-3 on any BCD nibble >= 5 before each shift.
REQ-013 Edge N+9 (DONE) SHALL commit hundreds/tens/ones/sign to the display register and leave DONE; o_busy high exactly 9 cycles per conversion.
REQ-014 SIGNED_MODE=1 with i_out[7]=1 SHALL convert magnitude = (~i_out+1) mod 256 and set sign. 8'h80 yields 128 with sign.
REQ-015 i_load during CONVERT SHALL store i_out in a one-deep pending register and set pending; a later load overwrites it (latest wins).
REQ-016 At DONE, i_load high SHALL start a new conversion from i_out and clear pending.
- Else, if pending is set, a conversion SHALL start from the pending value and clear pending.
- Else the FSM returns to IDLE.
- The commit of REQ-013 occurs on the same edge in every case.
REQ-017 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index advances 0->1->2->3->0.
REQ-018 Digit mapping: index 0 = ones, 1 = tens, 2 = hundreds, 3 = sign; o_an = ~(1 << index).
REQ-019 Blanking: hundreds blank if 0; tens blank if hundreds and tens both 0; ones always shown; sign digit shows minus only when sign is set, else blank.
REQ-020 Segment codes (o_seg) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- minus=0111111, blank=1111111
REQ-021 o_seg/o_an SHALL update one cycle after the digit index or display register changes.
- A committed value appears from edge N+10 on the currently scanned digit.
REQ-022 Scanning SHALL continue uninterrupted during conversions, showing the previous value until commit.

Reset
REQ-023 While i_rst=0 (asynchronously):
- state=IDLE, o_busy=0, pending=0
- display register = 0, sign = 0
- scan counter = 0, digit index = 0
- o_an=1111, o_seg=1111111
REQ-024 First rising edge after i_rst releases SHALL drive o_an=1110, o_seg=1000000 (value 0).
REQ-025 Reset asserted mid-conversion SHALL abort the conversion and discard pending without committing.

Verification (bench uses SCAN_DIV=4)
REQ-026 Reset: i_rst=0 -> o_an=1111, o_seg=1111111, o_busy=0; release -> next edge o_an=1110, o_seg=1000000.
REQ-027 Unsigned load 8'd255 -> o_busy high 9 cycles; digits 0/1/2 = 0010010/0010010/0100100; digit 3 = 1111111.
REQ-028 Load 8'd7 -> ones=1111000; tens and hundreds = 1111111.
REQ-029 SIGNED_MODE=1, load 8'hF6 -> ones=1000000, tens=1111001, hundreds=1111111, sign=0111111; load 8'h80 -> 1,2,8 with minus.
REQ-030 Load 12, then 34 and 56 during busy -> display 12, then 56 with no idle gap; 34 never shown; o_busy high 18 consecutive cycles.
REQ-031 Load 200, assert i_rst at edge N+4 -> o_busy=0 immediately; after release display shows 0 and no conversion follows.
